// File: rtl/player_pkg.sv
// Shared definitions for the player control FSM and the player datapath:
// arithmetic opcodes, render state encoding and screen dimensions.
package player_pkg;

    localparam logic [3:0] OP_RIGHT   = 4'b0000;
    localparam logic [3:0] OP_LEFT    = 4'b0001;
    localparam logic [3:0] OP_DOWN_LO = 4'b0010;
    localparam logic [3:0] OP_UP_LO   = 4'b0011;
    localparam logic [3:0] OP_DOWN_HI = 4'b0100;
    localparam logic [3:0] OP_UP_HI   = 4'b0101;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_ERASE = 2'd1,
        RS_DRAW  = 2'd2,
        RS_DONE  = 2'd3
    } render_state_t;

endpackage

// File: rtl/player_sprite_rom.sv
// Sprite bitmap ROM, registered read. Word = {transparent, colour[2:0]},
// addressed row-major (cy*SPR_W + cx).
module player_sprite_rom
    import player_pkg::*;
#(
    parameter int SPR_W = 8,
    parameter int SPR_H = 8,
    localparam int AW   = $clog2(SPR_W * SPR_H)
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    output logic [3:0]    data
);

    // Rounded-corner body: corners transparent, upper half yellow, lower half cyan.
    function automatic logic [3:0] rom_word(input int idx);
        int row;
        int col;
        row = idx / SPR_W;
        col = idx % SPR_W;
        if ((row == 0 || row == SPR_H - 1) && (col == 0 || col == SPR_W - 1))
            rom_word = 4'b1000;
        else if (row < SPR_H / 2)
            rom_word = 4'b0110;
        else
            rom_word = 4'b0011;
    endfunction

    always_ff @(posedge clock) begin
        data <= rom_word(int'(addr));
    end

endmodule

// File: rtl/player_datapath.sv
// Player position datapath and erase/redraw sprite renderer feeding the VGA plot port.
// Define PLAYER_DATAPATH_SPRITE_ROM_EN for a ROM-textured sprite (one extra output cycle).
module player_datapath
    import player_pkg::*;
#(
    parameter int         SPR_W      = 8,
    parameter int         SPR_H      = 8,
    parameter logic [7:0] X_START    = 8'd20,
    parameter logic [6:0] GROUND_Y   = 7'd100,
    parameter logic [7:0] X_MAX      = 8'd159,
    parameter int         STEP_X     = 4,
    parameter int         JUMP_HI    = 8,
    parameter int         JUMP_LO    = 4,
    parameter logic [2:0] BG_COLOUR  = 3'b000,
    parameter logic [2:0] SPR_COLOUR = 3'b111
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] calc_op,
    input  logic       calc_go,
    input  logic       load_p,
    input  logic       draw,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       draw_done,
    output logic [7:0] pos_x,
    output logic [6:0] pos_y
);

    localparam int                X_HI      = int'(X_MAX) - SPR_W + 1;
    localparam logic signed [8:0] X_HI_S    = 9'(X_HI);
    localparam logic signed [8:0] GROUND_S  = 9'(int'(GROUND_Y));
    localparam logic signed [8:0] STEP_X_S  = 9'(STEP_X);
    localparam logic signed [8:0] JUMP_HI_S = 9'(JUMP_HI);
    localparam logic signed [8:0] JUMP_LO_S = 9'(JUMP_LO);
    localparam logic [7:0]        CX_LAST   = 8'(SPR_W - 1);
    localparam logic [6:0]        CY_LAST   = 7'(SPR_H - 1);

    function automatic logic [7:0] sat_x(input logic signed [8:0] v);
        if (v < 9'sd0)
            sat_x = 8'd0;
        else if (v > X_HI_S)
            sat_x = X_HI_S[7:0];
        else
            sat_x = v[7:0];
    endfunction

    function automatic logic [6:0] sat_y(input logic signed [8:0] v);
        if (v < 9'sd0)
            sat_y = 7'd0;
        else if (v > GROUND_S)
            sat_y = GROUND_S[6:0];
        else
            sat_y = v[6:0];
    endfunction

    logic [7:0]        px, px_n;
    logic [6:0]        py, py_n;
    logic signed [8:0] px_s, py_s;

    always_comb begin
        px_s = signed'({1'b0, px});
        py_s = signed'({2'b00, py});
        px_n = px;
        py_n = py;
        if (calc_go) begin
            case (calc_op)
                OP_RIGHT:   px_n = sat_x(px_s + STEP_X_S);
                OP_LEFT:    px_n = sat_x(px_s - STEP_X_S);
                OP_UP_HI:   py_n = sat_y(py_s - JUMP_HI_S);
                OP_UP_LO:   py_n = sat_y(py_s - JUMP_LO_S);
                OP_DOWN_LO: py_n = sat_y(py_s + JUMP_LO_S);
                OP_DOWN_HI: py_n = sat_y(py_s + JUMP_HI_S);
                default:    ;
            endcase
        end
    end

    // Commit sees the pre-update pending value when calc_go and load_p coincide.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            px    <= X_START;
            py    <= GROUND_Y;
            pos_x <= X_START;
            pos_y <= GROUND_Y;
        end else begin
            px <= px_n;
            py <= py_n;
            if (load_p) begin
                pos_x <= px;
                pos_y <= py;
            end
        end
    end

    render_state_t state, state_n;
    logic          req, req_n;
    logic [7:0]    cx, cx_n;
    logic [6:0]    cy, cy_n;
    logic [7:0]    tx, tx_n, dx, dx_n;
    logic [6:0]    ty, ty_n, dy, dy_n;
    logic          last_col, last_pix;

    always_comb begin
        state_n  = state;
        req_n    = req | draw;
        cx_n     = cx;
        cy_n     = cy;
        tx_n     = tx;
        ty_n     = ty;
        dx_n     = dx;
        dy_n     = dy;
        last_col = (cx == CX_LAST);
        last_pix = last_col && (cy == CY_LAST);
        case (state)
            RS_IDLE: begin
                if (req || draw) begin
                    state_n = RS_ERASE;
                    req_n   = 1'b0;
                    cx_n    = 8'd0;
                    cy_n    = 7'd0;
                    tx_n    = pos_x;
                    ty_n    = pos_y;
                end
            end
            RS_ERASE, RS_DRAW: begin
                if (last_col) begin
                    cx_n = 8'd0;
                    cy_n = cy + 7'd1;
                end else begin
                    cx_n = cx + 8'd1;
                end
                if (last_pix) begin
                    state_n = (state == RS_ERASE) ? RS_DRAW : RS_DONE;
                    cx_n    = 8'd0;
                    cy_n    = 7'd0;
                end
            end
            RS_DONE: begin
                state_n = RS_IDLE;
                dx_n    = tx;
                dy_n    = ty;
            end
            default: state_n = RS_IDLE;
        endcase
    end

    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic       pix_on, pix_spr;

    always_comb begin
        pix_on  = (state == RS_ERASE) || (state == RS_DRAW);
        pix_spr = (state == RS_DRAW);
        pix_x   = 8'd0;
        pix_y   = 7'd0;
        if (state == RS_ERASE) begin
            pix_x = dx + cx;
            pix_y = dy + cy;
        end else if (state == RS_DRAW) begin
            pix_x = tx + cx;
            pix_y = ty + cy;
        end
    end

    logic       vld_p0, done_p0, busy_q;
    logic [7:0] x_p0;
    logic [6:0] y_p0;
    logic [2:0] col_p0;
`ifdef PLAYER_DATAPATH_SPRITE_ROM_EN
    logic       spr_p0;
`endif

    // Stage p0: FSM state and counters -> registered pixel command.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= RS_IDLE;
            req     <= 1'b0;
            cx      <= 8'd0;
            cy      <= 7'd0;
            tx      <= X_START;
            ty      <= GROUND_Y;
            dx      <= X_START;
            dy      <= GROUND_Y;
            vld_p0  <= 1'b0;
            done_p0 <= 1'b0;
            busy_q  <= 1'b0;
            x_p0    <= 8'd0;
            y_p0    <= 7'd0;
            col_p0  <= 3'b000;
`ifdef PLAYER_DATAPATH_SPRITE_ROM_EN
            spr_p0  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            req     <= req_n;
            cx      <= cx_n;
            cy      <= cy_n;
            tx      <= tx_n;
            ty      <= ty_n;
            dx      <= dx_n;
            dy      <= dy_n;
            vld_p0  <= pix_on;
            done_p0 <= (state == RS_DONE);
            busy_q  <= req_n || (state_n != RS_IDLE);
            x_p0    <= pix_x;
            y_p0    <= pix_y;
            col_p0  <= pix_on ? (pix_spr ? SPR_COLOUR : BG_COLOUR) : 3'b000;
`ifdef PLAYER_DATAPATH_SPRITE_ROM_EN
            spr_p0  <= pix_spr;
`endif
        end
    end

    assign busy = busy_q;

`ifdef PLAYER_DATAPATH_SPRITE_ROM_EN
    localparam int ROM_AW = $clog2(SPR_W * SPR_H);

    logic [ROM_AW-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic              vld_p1, done_p1;
    logic [7:0]        x_p1;
    logic [6:0]        y_p1;
    logic [2:0]        col_p1;

    // ROM is addressed alongside stage p0, so its data lines up with the p0 pixel.
    assign rom_addr = ROM_AW'(int'(cy) * SPR_W + int'(cx));

    player_sprite_rom #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_sprite_rom (
        .clock (clock),
        .addr  (rom_addr),
        .data  (rom_data)
    );

    // Stage p1: merge ROM texel; transparent texels suppress the write strobe.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            x_p1    <= 8'd0;
            y_p1    <= 7'd0;
            col_p1  <= 3'b000;
        end else begin
            vld_p1  <= vld_p0 && !(spr_p0 && rom_data[3]);
            done_p1 <= done_p0;
            x_p1    <= x_p0;
            y_p1    <= y_p0;
            col_p1  <= spr_p0 ? rom_data[2:0] : col_p0;
        end
    end

    assign vga_x     = x_p1;
    assign vga_y     = y_p1;
    assign colour    = col_p1;
    assign plot      = vld_p1;
    assign draw_done = done_p1;
`else
    assign vga_x     = x_p0;
    assign vga_y     = y_p0;
    assign colour    = col_p0;
    assign plot      = vld_p0;
    assign draw_done = done_p0;
`endif

endmodule

// File: tb/tb_player_datapath.sv
// Randomized self-checking bench for player_datapath (default build, solid sprite).
module tb_player_datapath;

    logic       clock = 1'b0;
    logic       resetn;
    logic [3:0] calc_op;
    logic       calc_go;
    logic       load_p;
    logic       draw;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       draw_done;
    logic [7:0] pos_x;
    logic [6:0] pos_y;

    int checks = 0;
    int errors = 0;

    localparam int W      = 8;
    localparam int H      = 8;
    localparam int X_HI   = 152;
    localparam int GROUND = 100;

    int m_px, m_py, m_posx, m_posy, m_dx, m_dy;

    typedef struct {
        bit plot;
        int x;
        int y;
        int col;
        bit done;
        bit busy;
    } cyc_t;
    cyc_t exp_q[$];

    player_datapath dut (
        .clock     (clock),
        .resetn    (resetn),
        .calc_op   (calc_op),
        .calc_go   (calc_go),
        .load_p    (load_p),
        .draw      (draw),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .draw_done (draw_done),
        .pos_x     (pos_x),
        .pos_y     (pos_y)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int next_x(input int x, input logic [3:0] op);
        int r;
        r = x;
        if (op == 4'b0000) r = x + 4;
        else if (op == 4'b0001) r = x - 4;
        if (r < 0) r = 0;
        if (r > X_HI) r = X_HI;
        return r;
    endfunction

    function automatic int next_y(input int y, input logic [3:0] op);
        int r;
        r = y;
        case (op)
            4'b0101: r = y - 8;
            4'b0011: r = y - 4;
            4'b0010: r = y + 4;
            4'b0100: r = y + 8;
            default: r = y;
        endcase
        if (r < 0) r = 0;
        if (r > GROUND) r = GROUND;
        return r;
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    task automatic model_reset();
        m_px = 20; m_py = 100; m_posx = 20; m_posy = 100; m_dx = 20; m_dy = 100;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic apply(input logic [3:0] op, input bit go, input bit ld);
        calc_op = op; calc_go = go; load_p = ld;
        step();
        calc_go = 1'b0; load_p = 1'b0;
        if (ld) begin m_posx = m_px; m_posy = m_py; end
        if (go) begin m_px = next_x(m_px, op); m_py = next_y(m_py, op); end
    endtask

    task automatic add_gap(input int n, input bit b);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c.plot = 0; c.x = 0; c.y = 0; c.col = 0; c.done = 0; c.busy = b;
            exp_q.push_back(c);
        end
    endtask

    // Erase the old footprint in background colour, then paint the new one; raster order.
    task automatic add_render(input int ox, input int oy, input int nx, input int ny, input bit pend);
        cyc_t c;
        for (int ph = 0; ph < 2; ph++)
            for (int r = 0; r < H; r++)
                for (int q = 0; q < W; q++) begin
                    c.plot = 1;
                    c.x    = (ph == 1 ? nx : ox) + q;
                    c.y    = (ph == 1 ? ny : oy) + r;
                    c.col  = (ph == 1) ? 7 : 0;
                    c.done = 0;
                    c.busy = 1;
                    exp_q.push_back(c);
                end
        c.plot = 0; c.x = 0; c.y = 0; c.col = 0; c.done = 1; c.busy = pend;
        exp_q.push_back(c);
    endtask

    task automatic test_reset();
        resetn = 1'b0; calc_op = 4'd0; calc_go = 1'b0; load_p = 1'b0; draw = 1'b0;
        repeat (3) step();
        checks++;
        if ({plot, busy, draw_done} !== 3'b000 || vga_x !== 8'd0 || vga_y !== 7'd0 || colour !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d, want all 0",
                     plot, busy, draw_done, vga_x, vga_y, colour);
        end
        checks++;
        if (pos_x !== 8'd20 || pos_y !== 7'd100) begin
            errors++;
            $display("FAIL reset_pos: got (%0d,%0d), want (20,100)", pos_x, pos_y);
        end
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_move();
        apply(4'b0000, 1, 0);
        apply(4'b0000, 0, 1);
        checks++;
        if (pos_x !== 8'd24 || pos_y !== 7'd100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL move_right: got x=%0d y=%0d busy=%0b, want x=24 y=100 busy=0", pos_x, pos_y, busy);
        end
    endtask

    task automatic test_jump();
        logic [3:0] ops [4];
        int         ys  [4];
        ops = '{4'b0101, 4'b0011, 4'b0010, 4'b0100};
        ys  = '{92, 88, 92, 100};
        for (int i = 0; i < 4; i++) begin
            apply(ops[i], 1, 0);
            apply(4'b0000, 0, 1);
            checks++;
            if (pos_y !== 7'(ys[i]) || pos_x !== 8'd24) begin
                errors++;
                $display("FAIL jump_%0d: got (%0d,%0d), want (24,%0d)", i, pos_x, pos_y, ys[i]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (10) apply(4'b0001, 1, 0);
        apply(4'b0000, 0, 1);
        checks++;
        if (pos_x !== 8'd0) begin
            errors++;
            $display("FAIL sat_left: got x=%0d, want 0", pos_x);
        end
        apply(4'b0100, 1, 0);
        apply(4'b0000, 0, 1);
        checks++;
        if (pos_y !== 7'd100) begin
            errors++;
            $display("FAIL sat_ground: got y=%0d, want 100", pos_y);
        end
        apply(4'b1111, 1, 0);
        apply(4'b0000, 0, 1);
        checks++;
        if (pos_x !== 8'd0 || pos_y !== 7'd100) begin
            errors++;
            $display("FAIL op_invalid: got (%0d,%0d), want (0,100)", pos_x, pos_y);
        end
        repeat (45) apply(4'b0000, 1, 0);
        repeat (15) apply(4'b0101, 1, 0);
        apply(4'b0000, 0, 1);
        checks++;
        if (pos_x !== 8'd152 || pos_y !== 7'd0) begin
            errors++;
            $display("FAIL sat_right_top: got (%0d,%0d), want (152,0)", pos_x, pos_y);
        end
    endtask

    task automatic test_random_ops();
        logic [3:0] op;
        bit go, ld;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            go = 1'($urandom_range(0, 1));
            ld = 1'($urandom_range(0, 1));
            apply(op, go, ld);
            checks++;
            if (pos_x !== 8'(m_posx) || pos_y !== 7'(m_posy)) begin
                errors++;
                $display("FAIL random_op_%0d: op=%0h go=%0b ld=%0b got (%0d,%0d), want (%0d,%0d)",
                         i, op, go, ld, pos_x, pos_y, m_posx, m_posy);
            end
        end
    endtask

    task automatic test_render();
        do_reset();
        apply(4'b0000, 1, 0);
        apply(4'b0000, 0, 1);
        exp_q.delete();
        add_gap(1, 1);
        add_render(m_dx, m_dy, m_posx, m_posy, 0);
        add_gap(2, 0);
        draw = 1'b1;
        foreach (exp_q[i]) begin
            step();
            draw = 1'b0;
            checks++;
            if (plot !== exp_q[i].plot || draw_done !== exp_q[i].done || busy !== exp_q[i].busy ||
                (exp_q[i].plot && (vga_x !== 8'(exp_q[i].x) || vga_y !== 7'(exp_q[i].y) ||
                                   colour !== 3'(exp_q[i].col)))) begin
                errors++;
                $display("FAIL render_c%0d: got plot=%0b done=%0b busy=%0b x=%0d y=%0d c=%0d, want plot=%0b done=%0b busy=%0b x=%0d y=%0d c=%0d",
                         i, plot, draw_done, busy, vga_x, vga_y, colour,
                         exp_q[i].plot, exp_q[i].done, exp_q[i].busy, exp_q[i].x, exp_q[i].y, exp_q[i].col);
            end
        end
        m_dx = m_posx; m_dy = m_posy;
    endtask

    task automatic test_back_to_back();
        logic [3:0] moves [3];
        logic [3:0] op;
        int t1x, t1y, t2x, t2y;
        moves = '{4'b0000, 4'b0101, 4'b0011};
        do_reset();
        apply(4'b0000, 1, 0);
        apply(4'b0000, 0, 1);
        op  = moves[$urandom_range(0, 2)];
        t1x = m_posx; t1y = m_posy;
        t2x = next_x(m_px, op); t2y = next_y(m_py, op);
        exp_q.delete();
        add_gap(1, 1);
        add_render(m_dx, m_dy, t1x, t1y, 1);
        add_gap(1, 1);
        add_render(t1x, t1y, t2x, t2y, 0);
        add_gap(1, 0);
        draw = 1'b1;
        foreach (exp_q[i]) begin
            if (i == 10) draw = 1'b1;
            if (i == 60) begin calc_op = op; calc_go = 1'b1; end
            if (i == 70) load_p = 1'b1;
            step();
            draw = 1'b0; calc_go = 1'b0; load_p = 1'b0;
            checks++;
            if (plot !== exp_q[i].plot || draw_done !== exp_q[i].done || busy !== exp_q[i].busy ||
                (exp_q[i].plot && (vga_x !== 8'(exp_q[i].x) || vga_y !== 7'(exp_q[i].y) ||
                                   colour !== 3'(exp_q[i].col)))) begin
                errors++;
                $display("FAIL b2b_c%0d: got plot=%0b done=%0b busy=%0b x=%0d y=%0d c=%0d, want plot=%0b done=%0b busy=%0b x=%0d y=%0d c=%0d",
                         i, plot, draw_done, busy, vga_x, vga_y, colour,
                         exp_q[i].plot, exp_q[i].done, exp_q[i].busy, exp_q[i].x, exp_q[i].y, exp_q[i].col);
            end
        end
        m_px = t2x; m_py = t2y; m_posx = t2x; m_posy = t2y; m_dx = t2x; m_dy = t2y;
    endtask

    task automatic test_reset_mid_render();
        int count;
        do_reset();
        apply(4'b0000, 1, 0);
        apply(4'b0000, 0, 1);
        draw = 1'b1;
        step();
        draw = 1'b0;
        count = 0;
        for (int k = 0; k < 200 && count < 40; k++) begin
            step();
            if (plot === 1'b1) count++;
        end
        checks++;
        if (count != 40) begin
            errors++;
            $display("FAIL midreset_plots: got %0d plots within budget, want 40", count);
        end
        resetn = 1'b0;
        step();
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || draw_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctrl: got plot=%0b busy=%0b done=%0b, want 0 0 0", plot, busy, draw_done);
        end
        checks++;
        if (pos_x !== 8'd20 || pos_y !== 7'd100) begin
            errors++;
            $display("FAIL midreset_pos: got (%0d,%0d), want (20,100)", pos_x, pos_y);
        end
        resetn = 1'b1;
        model_reset();
        step();
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got plot=%0b busy=%0b, want 0 0", plot, busy);
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_jump();
        test_saturation();
        test_random_ops();
        test_render();
        test_back_to_back();
        test_reset_mid_render();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_datapath.md
# player_datapath

Datapath and sprite renderer downstream of the player control FSM. Holds the player's pending and committed screen position, applies the FSM's `calc_op` arithmetic on `calc_go`, and commits it on `load_p`. On each `draw` pulse it erases the sprite at its last-drawn position and redraws it at the committed position, one pixel per cycle, into the VGA adapter's plot interface.

## Interface
- `SPR_W`, default 8: sprite width in pixels.
- `SPR_H`, default 8: sprite height in pixels.
- `X_START`, default 8'd20: reset x position.
- `GROUND_Y`, default 7'd100: reset y position and lowest allowed y.
- `X_MAX`, default 8'd159: rightmost screen column.
- `STEP_X`, default 4: horizontal move per op.
- `JUMP_HI`, default 8 / `JUMP_LO`, default 4: vertical jump increments.
- `BG_COLOUR`, default 3'b000 / `SPR_COLOUR`, default 3'b111.
- `clock` in 1: system clock.
- `resetn` in 1: synchronous, active-low reset; clock `clock`.
- `calc_op` in 4: arithmetic opcode from the FSM.
- `calc_go` in 1: apply `calc_op` to the pending position.
- `load_p` in 1: commit the pending position.
- `draw` in 1: single-cycle render request.
- `vga_x` out 8: pixel column.
- `vga_y` out 7: pixel row.
- `colour` out 3: pixel colour.
- `plot` out 1: pixel write strobe.
- `busy` out 1: render in progress or pending.
- `draw_done` out 1: single-cycle pulse when a render completes.
- `pos_x` out 8 / `pos_y` out 7: committed position.

## Operation
- Registers: pending `(px,py)`, committed `(pos_x,pos_y)`, last-drawn `(dx,dy)`.
- Reset state:
  - all three positions = `(X_START, GROUND_Y)`;
  - `plot`, `busy`, `draw_done` = 0;
  - `vga_x`, `vga_y`, `colour` = 0;
  - FSM in IDLE; request latch clear.
- `calc_go` updates the pending position by opcode. `py` decreases upward.
  - 0000: `px += STEP_X`
  - 0001: `px -= STEP_X`
  - 0101: `py -= JUMP_HI`
  - 0011: `py -= JUMP_LO`
  - 0010: `py += JUMP_LO`
  - 0100: `py += JUMP_HI`
  - any other opcode: no change.
- Consecutive `calc_go` cycles accumulate (e.g. 0101 then 0001 moves up and left).
- Arithmetic is done at 9 bits, then saturated:
  - `px` clamped to [0, `X_MAX-SPR_W+1`];
  - `py` clamped to [0, `GROUND_Y`].
- `load_p`: `pos <= p`. If `calc_go` and `load_p` arrive in the same cycle, `pos` takes the old `p` and `p` takes the updated value.
- Render FSM states: IDLE, ERASE, DRAW, DONE.
  - IDLE → ERASE when the request latch is set. On entry, `pos` is snapshotted as the draw target and the pixel counters `(cx,cy)` are cleared.
  - ERASE: plots `(dx+cx, dy+cy)` with `BG_COLOUR`. `cx` advances first, then `cy`. After pixel (`SPR_W-1`, `SPR_H-1`) → DRAW with counters cleared.
  - DRAW: plots snapshot `+ (cx,cy)` with `SPR_COLOUR`. After the last pixel → DONE.
  - DONE: `draw_done`=1 for one cycle, `(dx,dy)` <= snapshot, → IDLE.
- Request latch:
  - set by `draw` at any time; cleared on the IDLE→ERASE transition;
  - a `draw` arriving while rendering is kept (one deep) and serviced immediately after DONE;
  - multiple extra pulses collapse into one.
- `busy` = latch set OR state ≠ IDLE.
- Commits (`load_p`) during a render do not affect the pixels of that render.
- `resetn` low mid-render aborts at once: `plot` drops next edge and everything returns to reset values.

## Timing
- `draw` sampled high at edge N:
  - first `plot` at N+1;
  - `plot` is continuous for `2*SPR_W*SPR_H` cycles;
  - `draw_done` at N+1+2·W·H (N+129 for 8×8).
- `calc_go` and `load_p` take effect at the next edge. `pos_x`/`pos_y` are valid one cycle after `load_p`.
- All outputs are registered.

## Configuration
- `PLAYER_DATAPATH_SPRITE_ROM_EN` defined:
  - DRAW-phase colour comes from a `SPR_W*SPR_H` × 4-bit ROM (bit 3 = transparent). Transparent pixels drive `plot`=0.
  - The ROM read is registered, so `vga_x`/`vga_y`/`colour`/`plot` are delayed one extra cycle in all phases. This makes render latency +1: `draw_done` at N+2+2·W·H.
- Undefined: solid `SPR_COLOUR`, timing as above.

## Structure
- Shared package `player_pkg`:
  - opcode constants (`OP_RIGHT`=0000, `OP_LEFT`=0001, `OP_DOWN_LO`=0010, `OP_UP_LO`=0011, `OP_DOWN_HI`=0100, `OP_UP_HI`=0101);
  - render state enum;
  - screen dimension constants. The control FSM uses the same opcodes.
- One sub-module: `player_sprite_rom` (address = cy·SPR_W+cx, registered output), instantiated only under the macro.

## Test plan
- Reset, then `calc_go` op 0000 and `load_p`: `pos_x`=24, `pos_y`=100, `busy`=0.
- Jump sequence with ops 0101, 0011, 0010, 0100, each followed by `load_p`: `pos_y` goes 92, 88, 92, 100.
- `draw` at cycle N after moving to x=24:
  - 64 plots with colour 000 at x 20..27, y 100..107;
  - then 64 plots with colour 111 at x 24..31;
  - `draw_done` at N+129.
- Saturation: ten op 0001 from x=20 give `pos_x`=0. Op 0100 at ground leaves `pos_y`=100. Op 1111 causes no change.
- Second `draw` during ERASE plus `load_p` mid-render: the first render uses the old target; the second render starts the cycle after `draw_done` and erases the first target.
- `resetn` low at the 40th plot: next cycle `plot`=0, `busy`=0, position back to (20,100).
